// File: rtl/carryless_multiply_sequencer.sv
// carryless_multiply_sequencer
// Iterative GF(2) multiplier that scans the multiplier one bit per clock and
// returns the RISC-V Zbc CLMUL / CLMULH / CLMULR slices over valid/ready handshakes.
// Optional build macro: CLMUL_EARLY_EXIT_EN stops scanning once the remaining
// multiplier bits are all zero (every further step would be a no-op).
module carryless_multiply_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic [1:0]            op_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [2*W-1:0]  a_sh;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_step;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    b_next;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [W-1:0]    slice;
  logic            last_step;
  logic            accept;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign busy_o  = (state != IDLE);
  assign accept  = valid_i && ready_o;

  // One shift/XOR step: the product including this cycle's partial term,
  // and whether this step finishes the scan.
  always_comb begin
    acc_step  = b_sh[0] ? (acc ^ a_sh) : acc;
    b_next    = b_sh >> 1;
`ifdef CLMUL_EARLY_EXIT_EN
    last_step = (cnt == CW'(W - 1)) || (b_next == '0);
`else
    last_step = (cnt == CW'(W - 1));
`endif
  end

  // Select the requested slice of the final product; reserved op falls back to CLMUL.
  always_comb begin
    slice = acc_step[W-1:0];
    case (op_q)
      2'b01:   slice = acc_step[2*W-1:W];
      2'b10:   slice = acc_step[2*W-2:W-1];
      default: slice = acc_step[W-1:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept only in IDLE, release DONE only on the consumer handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef CLMUL_EARLY_EXIT_EN
          state_next = (operand_B_i == '0) ? DONE : COMPUTE;
`else
          state_next = COMPUTE;
`endif
        end
      end
      COMPUTE: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, step while computing, latch the slice on entry to DONE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      cnt      <= '0;
      op_q     <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh <= {{W{1'b0}}, operand_A_i};
            b_sh <= operand_B_i;
            acc  <= '0;
            cnt  <= '0;
            op_q <= op_i;
`ifdef CLMUL_EARLY_EXIT_EN
            if (operand_B_i == '0) begin
              result_o <= '0;
            end
`endif
          end
        end
        COMPUTE: begin
          acc  <= acc_step;
          a_sh <= a_sh << 1;
          b_sh <= b_next;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            result_o <= slice;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carryless_multiply_sequencer.sv
// tb_carryless_multiply_sequencer
// Directed and random checks of the sequential carry-less multiplier at W=32.
// Honours CLMUL_EARLY_EXIT_EN when computing expected latencies.
module tb_carryless_multiply_sequencer;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  operand_A_i;
  logic [W-1:0]  operand_B_i;
  logic [1:0]    op_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  result_o;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  carryless_multiply_sequencer #(.DATA_WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operand_A_i (operand_A_i),
    .operand_B_i (operand_B_i),
    .op_i        (op_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Reference carry-less product built from shifted copies of A.
  function automatic logic [W-1:0] ref_clmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    end
    case (op)
      2'b01:   return p[2*W-1:W];
      2'b10:   return p[2*W-2:W-1];
      default: return p[W-1:0];
    endcase
  endfunction

  // Edges from the accepting edge (counted as 1) until valid_o is seen.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef CLMUL_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (b[i]) return i + 2;
    end
    return 1;
`else
    return W + 1;
`endif
  endfunction

  // Issue one request with ready_i high, return its result and latency, finish the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        output logic [W-1:0] res, output int lat);
    @(negedge clk_i);
    operand_A_i = a;
    operand_B_i = b;
    op_i        = op;
    ready_i     = 1'b1;
    valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    res = result_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i     = 1'b0;
    valid_i     = 1'b1;
    ready_i     = 1'b0;
    operand_A_i = 32'h1234_5678;
    operand_B_i = 32'h0000_00FF;
    op_i        = 2'b00;
    repeat (3) @(negedge clk_i);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b busy=%b result=%h, want 1 0 0 00000000",
               ready_o, valid_o, busy_o, result_o);
    end
    valid_i = 1'b0;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    total++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release_idle: ready=%b busy=%b, want 1 0", ready_o, busy_o);
    end
  endtask

  task automatic test_clmul_basic();
    logic [W-1:0] res;
    int lat;
    run_op(32'h3, 32'h3, 2'b00, res, lat);
    total++;
    if (res !== 32'h0000_0005) begin
      bad++;
      $display("[TB] FAIL clmul_3x3: got %h want 00000005", res);
    end
    total++;
    if (lat !== exp_lat(32'h3)) begin
      bad++;
      $display("[TB] FAIL latency_3x3: got %0d want %0d", lat, exp_lat(32'h3));
    end
    run_op(32'h5, 32'h7, 2'b00, res, lat);
    total++;
    if (res !== 32'h0000_001B) begin
      bad++;
      $display("[TB] FAIL clmul_5x7: got %h want 0000001b", res);
    end
    run_op(32'h5, 32'h7, 2'b11, res, lat);
    total++;
    if (res !== 32'h0000_001B) begin
      bad++;
      $display("[TB] FAIL reserved_op_5x7: got %h want 0000001b", res);
    end
    run_op(32'h5, 32'h7, 2'b01, res, lat);
    total++;
    if (res !== 32'h0000_0000) begin
      bad++;
      $display("[TB] FAIL clmulh_5x7: got %h want 00000000", res);
    end
  endtask

  task automatic test_msb_vectors();
    logic [W-1:0] res;
    int lat;
    run_op(32'h8000_0000, 32'h8000_0000, 2'b01, res, lat);
    total++;
    if (res !== 32'h4000_0000) begin
      bad++;
      $display("[TB] FAIL clmulh_msb: got %h want 40000000", res);
    end
    total++;
    if (lat !== exp_lat(32'h8000_0000)) begin
      bad++;
      $display("[TB] FAIL latency_msb: got %0d want %0d", lat, exp_lat(32'h8000_0000));
    end
    run_op(32'h8000_0000, 32'h8000_0000, 2'b10, res, lat);
    total++;
    if (res !== 32'h8000_0000) begin
      bad++;
      $display("[TB] FAIL clmulr_msb: got %h want 80000000", res);
    end
    run_op(32'h8000_0000, 32'h8000_0000, 2'b00, res, lat);
    total++;
    if (res !== 32'h0000_0000) begin
      bad++;
      $display("[TB] FAIL clmul_msb: got %h want 00000000", res);
    end
  endtask

  task automatic test_ones_vectors();
    logic [W-1:0] res;
    int lat;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, res, lat);
    total++;
    if (res !== 32'h5555_5555) begin
      bad++;
      $display("[TB] FAIL clmul_ones: got %h want 55555555", res);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, res, lat);
    total++;
    if (res !== 32'h5555_5555) begin
      bad++;
      $display("[TB] FAIL clmulh_ones: got %h want 55555555", res);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, res, lat);
    total++;
    if (res !== 32'hAAAA_AAAA) begin
      bad++;
      $display("[TB] FAIL clmulr_ones: got %h want aaaaaaaa", res);
    end
  endtask

  task automatic test_zero_b();
    logic [W-1:0] res;
    int lat;
    run_op(32'hDEAD_BEEF, 32'h0, 2'b00, res, lat);
    total++;
    if (res !== 32'h0) begin
      bad++;
      $display("[TB] FAIL clmul_zero_b: got %h want 00000000", res);
    end
    total++;
    if (lat !== exp_lat(32'h0)) begin
      bad++;
      $display("[TB] FAIL latency_zero_b: got %0d want %0d", lat, exp_lat(32'h0));
    end
    run_op(32'hDEAD_BEEF, 32'h0, 2'b10, res, lat);
    total++;
    if (res !== 32'h0) begin
      bad++;
      $display("[TB] FAIL clmulr_zero_b: got %h want 00000000", res);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk_i);
    operand_A_i = 32'hFFFF_FFFF;
    operand_B_i = 32'hFFFF_FFFF;
    op_i        = 2'b10;
    ready_i     = 1'b0;
    valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      operand_A_i = 32'h0;
      operand_B_i = 32'h0;
      op_i        = 2'b00;
      valid_i     = 1'b1;
      @(posedge clk_i);
      #1;
      total++;
      if (valid_o !== 1'b1 || result_o !== 32'hAAAA_AAAA || ready_o !== 1'b0 || busy_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL backpressure_hold[%0d]: valid=%b result=%h ready=%b busy=%b, want 1 aaaaaaaa 0 1",
                 i, valid_o, result_o, ready_o, busy_o);
      end
    end
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'hAAAA_AAAA) begin
      bad++;
      $display("[TB] FAIL backpressure_release: ready=%b valid=%b busy=%b result=%h, want 1 0 0 aaaaaaaa",
               ready_o, valid_o, busy_o, result_o);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL no_same_cycle_accept: ready=%b want 1", ready_o);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] res;
    int lat;
    logic saw_valid;
    @(negedge clk_i);
    operand_A_i = 32'hFFFF_FFFF;
    operand_B_i = 32'hFFFF_FFFF;
    op_i        = 2'b00;
    ready_i     = 1'b1;
    valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_busy_before: busy=%b want 1", busy_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
      bad++;
      $display("[TB] FAIL abort_reset_outputs: ready=%b valid=%b busy=%b result=%h, want 1 0 0 00000000",
               ready_o, valid_o, busy_o, result_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (valid_o) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_no_valid_pulse: saw_valid=%b want 0", saw_valid);
    end
    run_op(32'h3, 32'h3, 2'b00, res, lat);
    total++;
    if (res !== 32'h5 || lat !== exp_lat(32'h3)) begin
      bad++;
      $display("[TB] FAIL abort_next_request: result=%h lat=%0d, want 00000005 %0d",
               res, lat, exp_lat(32'h3));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic got1;
    logic seen_idle;
    int n;
    int exp_gap;
    @(negedge clk_i);
    operand_A_i = 32'h5;
    operand_B_i = 32'h7;
    op_i        = 2'b00;
    ready_i     = 1'b1;
    valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    operand_A_i = 32'h3;
    operand_B_i = 32'h3;
    r1 = '0;
    got1 = 1'b0;
    seen_idle = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
      if (valid_o && !got1) begin
        r1 = result_o;
        got1 = 1'b1;
      end
      if (ready_o) seen_idle = 1'b1;
      else if (seen_idle) break;
    end
    valid_i = 1'b0;
    exp_gap = exp_lat(32'h7) + 1;
    total++;
    if (r1 !== 32'h0000_001B) begin
      bad++;
      $display("[TB] FAIL b2b_first_result: got %h want 0000001b", r1);
    end
    total++;
    if (n !== exp_gap) begin
      bad++;
      $display("[TB] FAIL b2b_throughput: accept gap %0d want %0d", n, exp_gap);
    end
    n = 0;
    while (!valid_o && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    r2 = result_o;
    @(posedge clk_i);
    #1;
    total++;
    if (r2 !== 32'h0000_0005) begin
      bad++;
      $display("[TB] FAIL b2b_second_result: got %h want 00000005", r2);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic [W-1:0] want;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      if (i % 10 == 3) b = b >> $urandom_range(1, 31);
      want = ref_clmul(a, b, op);
      run_op(a, b, op, res, lat);
      total++;
      if (res !== want || lat !== exp_lat(b)) begin
        bad++;
        $display("[TB] FAIL random[%0d] a=%h b=%h op=%0d: result=%h lat=%0d, want %h %0d",
                 i, a, b, op, res, lat, want, exp_lat(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clmul_basic();
    test_msb_vectors();
    test_ones_vectors();
    test_zero_b();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
